// File: rtl/reg_hazard_ctrl.sv
// reg_hazard_ctrl: hazard detection and operand forwarding control for the
// 5-stage MIPS16-style pipeline.
//
// Three in-flight write slots (EX, MEM, WB) follow the instructions that have
// left decode. Decode read addresses are compared against them to produce a
// load-use stall, a bubble request and per-operand forwarding selects.
//
// Handshake: there is no valid/ready pair here. id_issue qualifies the decode
// inputs. hold_in freezes every slot and forces stall for that cycle. flush
// squashes whatever would enter EX on the next edge.
//
// The load flag is kept only for the EX slot. Once a load reaches MEM its
// data is available at MEM/WB, so it forwards like any other result.
module reg_hazard_ctrl #(
  parameter int                 REG_W    = 4,
  parameter logic [REG_W-1:0]   NONE_REG = {REG_W{1'b1}},
  parameter int                 CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_issue,
  input  logic             hold_in,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0]       FWD_RF  = 2'd0;
  localparam logic [1:0]       FWD_EX  = 2'd1;
  localparam logic [1:0]       FWD_MEM = 2'd2;
  localparam logic [1:0]       FWD_WB  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Slot state
  logic             ex_v_q,  ex_v_d;
  logic [REG_W-1:0] ex_reg_q, ex_reg_d;
  logic             ex_ld_q, ex_ld_d;
  logic             mem_v_q, mem_v_d;
  logic [REG_W-1:0] mem_reg_q, mem_reg_d;
  logic             wb_v_q,  wb_v_d;
  logic [REG_W-1:0] wb_reg_q, wb_reg_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Operand/slot match terms
  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic luse;

  // Compare decode read addresses against every valid slot; NONE_REG never matches.
  always_comb begin
    a_ex  = ex_v_q  && (ex_reg_q  == id_rs) && (id_rs != NONE_REG);
    a_mem = mem_v_q && (mem_reg_q == id_rs) && (id_rs != NONE_REG);
    a_wb  = wb_v_q  && (wb_reg_q  == id_rs) && (id_rs != NONE_REG);
    b_ex  = ex_v_q  && (ex_reg_q  == id_rt) && (id_rt != NONE_REG);
    b_mem = mem_v_q && (mem_reg_q == id_rt) && (id_rt != NONE_REG);
    b_wb  = wb_v_q  && (wb_reg_q  == id_rt) && (id_rt != NONE_REG);
    luse  = id_issue && ex_ld_q && (a_ex || b_ex);
  end

  // Stall/bubble and forwarding selects; a load in EX cannot forward, so it falls through.
  always_comb begin
    stall  = hold_in || luse;
    bubble = luse && !hold_in;

    if (a_ex && !ex_ld_q) fwd_a = FWD_EX;
    else if (a_mem)       fwd_a = FWD_MEM;
    else if (a_wb)        fwd_a = FWD_WB;
    else                  fwd_a = FWD_RF;

    if (b_ex && !ex_ld_q) fwd_b = FWD_EX;
    else if (b_mem)       fwd_b = FWD_MEM;
    else if (b_wb)        fwd_b = FWD_WB;
    else                  fwd_b = FWD_RF;
  end

  // Next slot contents: hold freezes everything, otherwise shift and load EX.
  always_comb begin
    ex_v_d    = ex_v_q;
    ex_reg_d  = ex_reg_q;
    ex_ld_d   = ex_ld_q;
    mem_v_d   = mem_v_q;
    mem_reg_d = mem_reg_q;
    wb_v_d    = wb_v_q;
    wb_reg_d  = wb_reg_q;
    if (!hold_in) begin
      wb_v_d    = mem_v_q;
      wb_reg_d  = mem_reg_q;
      mem_v_d   = ex_v_q;
      mem_reg_d = ex_reg_q;
      if (flush || luse || !id_issue) begin
        ex_v_d   = 1'b0;
        ex_reg_d = NONE_REG;
        ex_ld_d  = 1'b0;
      end else begin
        ex_v_d   = (id_wr_reg != NONE_REG);
        ex_reg_d = id_wr_reg;
        ex_ld_d  = id_is_load;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Slot and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q      <= 1'b0;
      ex_reg_q    <= NONE_REG;
      ex_ld_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_reg_q   <= NONE_REG;
      wb_v_q      <= 1'b0;
      wb_reg_q    <= NONE_REG;
      stall_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_reg_q    <= ex_reg_d;
      ex_ld_q     <= ex_ld_d;
      mem_v_q     <= mem_v_d;
      mem_reg_q   <= mem_reg_d;
      wb_v_q      <= wb_v_d;
      wb_reg_q    <= wb_reg_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Directed bench for reg_hazard_ctrl. A second instance with a 4-bit stall
// counter exercises saturation. Inputs change 1 ns after the rising edge.
// Outputs are checked 1 ns later, well away from the active edge.
module tb_reg_hazard_ctrl;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  id_rs, id_rt, id_wr_reg;
  logic        id_is_load, id_issue, hold_in, flush, hold_sat;
  logic        stall, bubble, stall_s, bubble_s;
  logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int checks   = 0;
  int failures = 0;

  reg_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_issue(id_issue), .hold_in(hold_in), .flush(flush),
    .stall(stall), .bubble(bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  reg_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_issue(id_issue), .hold_in(hold_sat), .flush(flush),
    .stall(stall_s), .bubble(bubble_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic issue, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] wr, input logic ld);
    id_issue   = issue;
    id_rs      = rs;
    id_rt      = rt;
    id_wr_reg  = wr;
    id_is_load = ld;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
    repeat (3) tick();
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hold_in = 1'b0; flush = 1'b0; hold_sat = 1'b0;
    drive(1'b0, 4'hF, 4'hF, 4'hF, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall",  stall,     0);
    chk("rst_bubble", bubble,    0);
    chk("rst_fwd_a",  fwd_a,     0);
    chk("rst_fwd_b",  fwd_b,     0);
    chk("rst_cnt",    stall_cnt, 0);

    // Load-use on operand A
    drive(1'b1, 4'hF, 4'hF, 4'd3, 1'b1);
    chk("lu_issue_stall", stall, 0);
    tick();
    drive(1'b1, 4'd3, 4'hF, 4'd5, 1'b0);
    chk("lu_stall",  stall,  1);
    chk("lu_bubble", bubble, 1);
    chk("lu_fwd_a_hold", fwd_a, 0);
    tick();
    chk("lu_after_stall", stall,     0);
    chk("lu_fwd_a_mem",   fwd_a,     2);
    chk("lu_cnt",         stall_cnt, 1);
    tick();
    drain();

    // Forward priority EX > MEM > WB
    drive(1'b1, 4'hF, 4'hF, 4'd2, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hF, 4'd2, 1'b0);
    tick();
    drive(1'b1, 4'd2, 4'd2, 4'hF, 1'b0);
    chk("pri_fwd_b_ex", fwd_b, 1);
    chk("pri_fwd_a_ex", fwd_a, 1);
    chk("pri_stall",    stall, 0);
    tick();
    drive(1'b0, 4'hF, 4'd2, 4'hF, 1'b0);
    chk("pri_fwd_b_mem", fwd_b, 2);
    tick();
    chk("pri_fwd_b_wb", fwd_b, 3);
    tick();
    chk("pri_fwd_b_rf", fwd_b, 0);
    drain();

    // SP, IH, none and reserved codes
    drive(1'b1, 4'hF, 4'hF, 4'd8, 1'b0);
    tick();
    drive(1'b1, 4'd8, 4'hF, 4'd10, 1'b0);
    chk("sp_fwd_a_ex", fwd_a, 1);
    tick();
    drive(1'b1, 4'd10, 4'd8, 4'hF, 1'b1);
    chk("ih_fwd_a_ex",  fwd_a, 1);
    chk("sp_fwd_b_mem", fwd_b, 2);
    tick();
    drive(1'b1, 4'hF, 4'hF, 4'd12, 1'b0);
    chk("none_fwd_a", fwd_a, 0);
    chk("none_fwd_b", fwd_b, 0);
    chk("none_stall", stall, 0);
    tick();
    drive(1'b1, 4'hF, 4'd12, 4'hF, 1'b0);
    chk("rsv_fwd_b_ex", fwd_b, 1);
    tick();
    drain();

    // Flush squashes the load entering EX
    flush = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 4'd1, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b1, 4'd1, 4'hF, 4'hF, 1'b0);
    chk("flush_stall", stall, 0);
    chk("flush_fwd_a", fwd_a, 0);
    tick();
    drain();

    // Hold freezes slots; load-use on R4 resolves after release (stall_cnt 1 -> 5)
    drive(1'b1, 4'hF, 4'hF, 4'd4, 1'b1);
    tick();
    hold_in = 1'b1;
    drive(1'b1, 4'd4, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall",  stall,  1);
      chk("hold_bubble", bubble, 0);
      tick();
    end
    hold_in = 1'b0;
    #1;
    chk("hold_rel_stall",  stall,  1);
    chk("hold_rel_bubble", bubble, 1);
    tick();
    chk("hold_post_stall", stall,     0);
    chk("hold_post_fwd_a", fwd_a,     2);
    chk("hold_cnt",        stall_cnt, 5);
    tick();
    drain();

    // Reset mid-operation with R1/R2/R3 in flight
    drive(1'b1, 4'hF, 4'hF, 4'd1, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hF, 4'd2, 1'b0);
    tick();
    drive(1'b1, 4'hF, 4'hF, 4'd3, 1'b0);
    tick();
    drive(1'b0, 4'd1, 4'd2, 4'hF, 1'b0);
    chk("pre_rst_fwd_a", fwd_a, 3);
    chk("pre_rst_fwd_b", fwd_b, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 4'd1, 4'd2, 4'hF, 1'b0);
    chk("mid_rst_fwd_a", fwd_a,     0);
    chk("mid_rst_fwd_b", fwd_b,     0);
    chk("mid_rst_stall", stall,     0);
    chk("mid_rst_cnt",   stall_cnt, 0);
    drive(1'b0, 4'd3, 4'd3, 4'hF, 1'b0);
    chk("mid_rst_fwd_r3", fwd_a, 0);

    // Saturation on the 4-bit counter: 2^4 + 5 stalled cycles
    hold_sat = 1'b1;
    repeat (14) tick();
    chk("sat_cnt_14",   stall_cnt_s, 14);
    chk("sat_stall",    stall_s,     1);
    repeat (7) tick();
    chk("sat_cnt_15",   stall_cnt_s, 15);
    chk("sat_main_cnt", stall_cnt,   0);
    hold_sat = 1'b0;
    tick();
    chk("sat_cnt_hold", stall_cnt_s, 15);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_hazard_ctrl.md
Name: reg_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage MIPS16-style pipeline. It tracks in-flight register writes over the 4-bit register space (R0–R7 = 0–7, SP = 8, T = 9, IH = 10, 15 = none). It compares them against the decode-stage read addresses produced by the read-register decoders. It drives the decode stall, bubble insertion and per-operand forwarding selects, and keeps a saturating stall counter for debug.

Parameters:
REG_W, 4, register address width
NONE_REG, 4'hF, "no register" code; never matches and is never tracked
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
id_rs  input  REG_W  decode operand A read address
id_rt  input  REG_W  decode operand B read address
id_wr_reg  input  REG_W  decode destination (NONE_REG if no write)
id_is_load  input  1  decode instruction is LW/LW_SP
id_issue  input  1  valid instruction present in decode
hold_in  input  1  global freeze (memory structural stall)
flush  input  1  branch/jump taken: squash instruction entering EX
stall  output  1  hold PC and IF/ID register
bubble  output  1  insert NOP into ID/EX this cycle
fwd_a  output  2  operand A source: 0 regfile, 1 EX/MEM ALU result, 2 MEM/WB data, 3 WB write-back data
fwd_b  output  2  operand B source, same encoding
stall_cnt  output  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- State: three slots EX, MEM, WB, each {v, reg, ld}. Reset clears all v to 0 and reg to NONE_REG; stall_cnt = 0.
- Combinational outputs after reset, with slots empty: stall = 0, bubble = 0, fwd_a = fwd_b = 0 (hold_in = 0 assumed).
- Match rule: operand X matches slot S iff S.v = 1, S.reg = X, and X != NONE_REG.
- Load-use: luse = id_issue and EX.ld and (id_rs matches EX or id_rt matches EX).
- stall = hold_in or luse.
- bubble = luse and not hold_in.
- Forward select, per operand, priority EX > MEM > WB:
  - matches EX and not EX.ld → 1
  - else matches MEM → 2
  - else matches WB → 3
  - else 0
  - Selects are valid whenever id_issue = 1. Loads in MEM forward via select 2, since load data is present at MEM/WB.
- Slot update on rising edge, when not rst:
  - hold_in = 1: all slots keep their values. Hold takes precedence over flush and issue.
  - Otherwise: WB <= MEM and MEM <= EX.
  - EX load, in this order:
    - EX <= empty if flush, or luse, or not id_issue
    - else EX <= {id_wr_reg != NONE_REG, id_wr_reg, id_is_load}
- Simultaneous flush and luse: EX is empty and stall still asserts that cycle. The instruction in decode is squashed by the fetch logic, not by this block.
- A load is tracked for write-back even if it targets R0; R0 is an ordinary register in this ISA.
- stall_cnt increments by 1 on each edge where stall = 1, saturates at all-ones, and is cleared only by rst.
- Reset mid-operation: all slots cleared on the same edge. The next cycle has stall = 0 and fwd = 0 regardless of inputs, except hold_in.
- Latency: outputs are purely combinational from current inputs and slot state. Slot state advances one stage per unheld cycle.
- Reserved codes 11–14 are tracked like normal registers.

Test Plan:
- Load-use on operand A: issue LW R3 (id_wr_reg = 3, id_is_load = 1), then id_rs = 3 → stall = 1 and bubble = 1 for one cycle. Next cycle stall = 0 and fwd_a = 2. stall_cnt = 1.
- Forward priority: issue ADDU→R2, then ADDU→R2, then read id_rt = 2 → fwd_b = 1. Next cycle with no issue and id_rt = 2 → fwd_b = 2. One more idle cycle → fwd_b = 3, then 0.
- SP/IH/none: issue write SP (8), then read id_rs = 8 → fwd_a = 1. Issue id_wr_reg = 15, then read id_rs = 15 → fwd_a = 0 and stall = 0.
- Flush: issue LW R1 with flush = 1, then read id_rs = 1 → stall = 0 and fwd_a = 0.
- hold_in: with LW R4 in EX, assert hold_in for 3 cycles → stall = 1 and bubble = 0 each cycle; slots are unchanged after release, so a load-use on R4 then stalls once. stall_cnt increases by 4.
- Reset mid-op: with slots full (R1, R2, R3), assert rst for one cycle → next cycle fwd_a = fwd_b = 0 for reads of 1/2/3, stall_cnt = 0. Separately, force stall for 2^CNT_W + 5 cycles (CNT_W = 4 override) → stall_cnt = 15.
